alu_bist: RTL and testbench

- Hardware built-in self-test engine for the Alu block.
- It generates pseudo-random operand pairs and walks every supported op code. It drives them into an Alu instance and samples aluout/compout.
- Each sample is compared against an internal golden model.
- Each run counts mismatches and reports pass/fail. This is the synthesizable counterpart of the random-stimulus benches, usable on silicon and in regression.

---
 rtl/alu_bist.sv | 205 ++++++++++++++++++++
 tb/tb_alu_bist.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_bist.sv
// Built-in self-test engine for the Alu: LFSR operand pairs walk every op code,
// Alu results are checked against an internal golden model, and mismatches are counted.
module alu_bist #(
   parameter int          WIDTH       = 32,
   parameter int          NUM_VECTORS = 64,
   parameter logic [31:0] SEED_A      = 32'hACE12468,
   parameter logic [31:0] SEED_B      = 32'h1357BDF9,
   parameter int          ALU_LAT     = 1,
   parameter bit          CHECK_COMP  = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [15:0]      err_count,
   output logic [15:0]      first_err_idx,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [2:0]       alu_op,
   output logic             alu_unsig,
   input  logic [WIDTH-1:0] alu_aluout,
   input  logic             alu_compout
);
   localparam logic [31:0] LFSR_TAPS  = 32'h80200003;
   localparam logic [15:0] LAST_IDX   = 16'(NUM_VECTORS - 1);
   localparam logic [2:0]  DRAIN_LAST = 3'(ALU_LAT);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

   typedef struct packed {
      logic             vld;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [2:0]       op;
      logic             unsig;
      logic [15:0]      idx;
   } vec_t;

   function automatic logic [31:0] lfsr_step(input logic [31:0] s);
      if (s[0]) begin
         lfsr_step = (s >> 1) ^ LFSR_TAPS;
      end else begin
         lfsr_step = s >> 1;
      end
   endfunction

   function automatic logic [2:0] op_sel(input logic [2:0] i);
      case (i)
         3'd0:    op_sel = 3'b000;
         3'd1:    op_sel = 3'b001;
         3'd2:    op_sel = 3'b010;
         3'd3:    op_sel = 3'b100;
         3'd4:    op_sel = 3'b101;
         3'd5:    op_sel = 3'b110;
         default: op_sel = 3'b000;
      endcase
   endfunction

   // Returns {compout, result}; compout is only meaningful for SUB.
   function automatic logic [WIDTH:0] golden(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                             input logic [2:0] op, input logic unsig);
      logic [WIDTH-1:0] r;
      logic             c;
      r = '0;
      c = 1'b0;
      case (op)
         3'b000:  r = a & b;
         3'b001:  r = a | b;
         3'b010:  r = a + b;
         3'b100:  r = ~(a | b);
         3'b101:  r = a ^ b;
         3'b110: begin
            r = a - b;
            c = unsig ? (a < b) : ($signed(a) < $signed(b));
         end
         default: r = '0;
      endcase
      golden = {c, r};
   endfunction

   state_t           state_r;
   state_t           state_s;
   logic [31:0]      lfsr_a_r;
   logic [31:0]      lfsr_b_r;
   logic [15:0]      vec_idx_r;
   logic [2:0]       op_idx_r;
   logic             phase_r;
   logic [2:0]       drain_cnt_r;
   vec_t             pipe_r [ALU_LAT];
   vec_t             drive_s;
   vec_t             sample_s;
   logic [WIDTH:0]   expect_s;
   logic             mismatch_s;

   // Next-state decode
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) state_s = RUN;
            else       state_s = IDLE;
         end
         RUN: begin
            if (vec_idx_r == LAST_IDX) state_s = DRAIN;
            else                       state_s = RUN;
         end
         DRAIN: begin
            if (drain_cnt_r == DRAIN_LAST) state_s = DONE;
            else                           state_s = DRAIN;
         end
         DONE:    state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // Vector being driven this cycle and the delayed vector whose result is now due
   always_comb begin
      drive_s    = {1'b1, lfsr_a_r[WIDTH-1:0], lfsr_b_r[WIDTH-1:0], op_sel(op_idx_r), phase_r, vec_idx_r};
      sample_s   = pipe_r[ALU_LAT-1];
      expect_s   = golden(sample_s.a, sample_s.b, sample_s.op, sample_s.unsig);
      mismatch_s = 1'b0;
      if (sample_s.vld) begin
         if (alu_aluout != expect_s[WIDTH-1:0]) begin
            mismatch_s = 1'b1;
         end else if (CHECK_COMP && (sample_s.op == 3'b110) && (alu_compout != expect_s[WIDTH])) begin
            mismatch_s = 1'b1;
         end else begin
            mismatch_s = 1'b0;
         end
      end else begin
         mismatch_s = 1'b0;
      end
   end

   // FSM state, status reporting and operand generation
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r       <= IDLE;
         busy          <= 1'b0;
         done          <= 1'b0;
         pass          <= 1'b0;
         err_count     <= 16'd0;
         first_err_idx <= 16'hFFFF;
         alu_a         <= '0;
         alu_b         <= '0;
         alu_op        <= 3'b000;
         alu_unsig     <= 1'b0;
         lfsr_a_r      <= 32'd0;
         lfsr_b_r      <= 32'd0;
         vec_idx_r     <= 16'd0;
         op_idx_r      <= 3'd0;
         phase_r       <= 1'b0;
         drain_cnt_r   <= 3'd0;
      end else begin
         state_r     <= state_s;
         busy        <= (state_s == RUN) || (state_s == DRAIN);
         done        <= (state_s == DONE);
         drain_cnt_r <= (state_r == DRAIN) ? drain_cnt_r + 3'd1 : 3'd0;
         if ((state_r == IDLE) && start) begin
            lfsr_a_r      <= SEED_A;
            lfsr_b_r      <= SEED_B;
            vec_idx_r     <= 16'd0;
            op_idx_r      <= 3'd0;
            phase_r       <= 1'b0;
            err_count     <= 16'd0;
            first_err_idx <= 16'hFFFF;
            pass          <= 1'b0;
         end else begin
            if (mismatch_s) begin
               if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
               if (first_err_idx == 16'hFFFF) first_err_idx <= sample_s.idx;
            end
            if (state_s == DONE) pass <= (err_count == 16'd0);
            if (state_r == RUN) begin
               alu_a     <= drive_s.a;
               alu_b     <= drive_s.b;
               alu_op    <= drive_s.op;
               alu_unsig <= drive_s.unsig;
               lfsr_a_r  <= lfsr_step(lfsr_a_r);
               lfsr_b_r  <= lfsr_step(lfsr_b_r);
               vec_idx_r <= vec_idx_r + 16'd1;
               // unsig flips every full pass through the six op codes
               if (op_idx_r == 3'd5) begin
                  op_idx_r <= 3'd0;
                  phase_r  <= ~phase_r;
               end else begin
                  op_idx_r <= op_idx_r + 3'd1;
               end
            end
         end
      end
   end

   // Delay line aligning each driven vector with its Alu result
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ALU_LAT; i++) pipe_r[i] <= '0;
      end else begin
         pipe_r[0] <= (state_r == RUN) ? drive_s : '0;
         for (int i = 1; i < ALU_LAT; i++) pipe_r[i] <= pipe_r[i-1];
      end
   end
endmodule

// File: tb/tb_alu_bist.sv
// Scoreboard bench for alu_bist: three configurations, a fault-injectable Alu model,
// expected vectors/results queued at stimulus time and checked by per-instance monitors.
`timescale 1ns/1ps
module tb_alu_bist;
   localparam int NI = 3;
   localparam int NV  [NI] = '{64, 7, 1};
   localparam int LAT [NI] = '{1, 2, 1};
   localparam bit CC  [NI] = '{1'b1, 1'b0, 1'b1};
   localparam logic [31:0] SA = 32'hACE12468;
   localparam logic [31:0] SB = 32'h1357BDF9;
   localparam logic [2:0] OPS [6] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b110};

   typedef struct { logic [31:0] a; logic [31:0] b; logic [2:0] op; logic u; } vec_t;
   typedef struct { int when; logic pass; logic [15:0] err; logic [15:0] first; } res_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [NI-1:0]        rst, start, busy, done, pass, uns;
   logic [NI-1:0][15:0]  errc, first;
   logic [NI-1:0][31:0]  aa, bb;
   logic [NI-1:0][2:0]   op;
   int   mode  [NI];
   int   edge0 [NI];
   bit   armed [NI];
   vec_t vq [NI][$];
   res_t rq [NI][$];
   int   total = 0;
   int   bad = 0;

   // Alu behaviour; md injects a fault: 1 bit0 stuck 0, 2 NOR inverted, 3 compout stuck 0
   function automatic logic [32:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] o, input logic u, input int md);
      logic [31:0] r;
      logic        c;
      c = 1'b0;
      case (o)
         3'b000:  r = a & b;
         3'b001:  r = a | b;
         3'b010:  r = a + b;
         3'b100:  r = ~(a | b);
         3'b101:  r = a ^ b;
         3'b110: begin
            r = a - b;
            c = u ? (a < b) : ($signed(a) < $signed(b));
         end
         default: r = 32'd0;
      endcase
      if (md == 1) r[0] = 1'b0;
      if (md == 2 && o == 3'b100) r = ~r;
      if (md == 3) c = 1'b0;
      return {c, r};
   endfunction

   function automatic logic [31:0] lfsr_next(input logic [31:0] s);
      return s[0] ? ((s >> 1) ^ 32'h80200003) : (s >> 1);
   endfunction

   task automatic chk(input string nm, input int g, input logic [95:0] act, input logic [95:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s[%0d] got=%0h want=%0h", nm, g, act, exp);
      end
   endtask

   for (genvar g = 0; g < NI; g++) begin : gi
      logic [32:0] rc_s;
      logic [31:0] res_l;
      logic        comp_l;
      assign rc_s = alu_ref(aa[g], bb[g], op[g], uns[g], mode[g]);
      if (LAT[g] == 1) begin : comb_alu
         assign res_l  = rc_s[31:0];
         assign comp_l = rc_s[32];
      end else begin : reg_alu
         always @(posedge clk) begin
            res_l  <= rc_s[31:0];
            comp_l <= rc_s[32];
         end
      end

      alu_bist #(.NUM_VECTORS(NV[g]), .ALU_LAT(LAT[g]), .CHECK_COMP(CC[g])) dut (
         .clk(clk), .rst(rst[g]), .start(start[g]), .busy(busy[g]), .done(done[g]),
         .pass(pass[g]), .err_count(errc[g]), .first_err_idx(first[g]),
         .alu_a(aa[g]), .alu_b(bb[g]), .alu_op(op[g]), .alu_unsig(uns[g]),
         .alu_aluout(res_l), .alu_compout(comp_l));

      always @(negedge clk) begin
         int   rel;
         vec_t v;
         res_t r;
         rel = cyc - edge0[g];
         if (armed[g] && rel >= 1 && rel <= NV[g]) begin
            if (vq[g].size() == 0) begin
               total++; bad++;
               $display("FAIL vec_queue[%0d] got=empty want=vector at rel %0d", g, rel);
            end else begin
               v = vq[g].pop_front();
               chk("vector", g, 96'({aa[g], bb[g], op[g], uns[g]}), 96'({v.a, v.b, v.op, v.u}));
            end
         end
         if (armed[g] && rel >= 0 && rel <= NV[g] + LAT[g] + 1)
            chk("busy", g, 96'(busy[g]), 96'(rel <= NV[g] + LAT[g]));
         if (done[g]) begin
            if (rq[g].size() == 0) begin
               total++; bad++;
               $display("FAIL spurious_done[%0d] got=done want=no done at cycle %0d", g, cyc);
            end else begin
               r = rq[g].pop_front();
               chk("done_edge", g, 96'(rel), 96'(r.when));
               chk("pass", g, 96'(pass[g]), 96'(r.pass));
               chk("err_count", g, 96'(errc[g]), 96'(r.err));
               chk("first_err_idx", g, 96'(first[g]), 96'(r.first));
            end
         end
      end
   end

   task automatic check_reset(input int g);
      chk("rst_busy", g, 96'(busy[g]), 96'd0);
      chk("rst_done", g, 96'(done[g]), 96'd0);
      chk("rst_pass", g, 96'(pass[g]), 96'd0);
      chk("rst_err", g, 96'(errc[g]), 96'd0);
      chk("rst_first", g, 96'(first[g]), 96'hFFFF);
      chk("rst_ab", g, 96'({aa[g], bb[g]}), 96'd0);
      chk("rst_op_unsig", g, 96'({op[g], uns[g]}), 96'd0);
   endtask

   task automatic run(input int g, input int md, input int rst_at, input int repulse_at);
      logic [31:0] a, b;
      logic [32:0] good, got;
      logic [15:0] err, fst;
      res_t r;
      vec_t v;
      int   budget;
      bit   did_rst;
      mode[g] = md;
      a = SA; b = SB; err = 16'd0; fst = 16'hFFFF;
      for (int k = 0; k < NV[g]; k++) begin
         v.a = a; v.b = b; v.op = OPS[k % 6]; v.u = ((k / 6) % 2) == 1;
         vq[g].push_back(v);
         good = alu_ref(a, b, v.op, v.u, 0);
         got  = alu_ref(a, b, v.op, v.u, md);
         if ((got[31:0] != good[31:0]) || (CC[g] && v.op == 3'b110 && got[32] != good[32])) begin
            if (err != 16'hFFFF) err = err + 16'd1;
            if (fst == 16'hFFFF) fst = 16'(k);
         end
         a = lfsr_next(a);
         b = lfsr_next(b);
      end
      r.when = NV[g] + LAT[g] + 1; r.pass = (err == 16'd0); r.err = err; r.first = fst;
      rq[g].push_back(r);
      @(posedge clk); #2;
      edge0[g] = cyc + 1; armed[g] = 1'b1; start[g] = 1'b1;
      budget = 0;
      did_rst = 1'b0;
      while (rq[g].size() != 0 && budget < NV[g] + LAT[g] + 20) begin
         @(posedge clk); #2;
         budget++;
         start[g] = 1'b0;
         if (repulse_at > 0 && (cyc - edge0[g]) == repulse_at) start[g] = 1'b1;
         if (rst_at > 0 && (cyc - edge0[g]) == rst_at) begin
            rst[g] = 1'b1; armed[g] = 1'b0;
            vq[g].delete(); rq[g].delete();
            @(posedge clk); #2;
            rst[g] = 1'b0;
            check_reset(g);
            did_rst = 1'b1;
            break;
         end
      end
      start[g] = 1'b0;
      if (rq[g].size() != 0) begin
         total++; bad++;
         $display("FAIL timeout[%0d] got=no done want=done within %0d cycles", g, budget);
         vq[g].delete(); rq[g].delete();
      end else if (did_rst) begin
         repeat (NV[g] + LAT[g] + 10) begin @(posedge clk); #2; end
      end else begin
         repeat (3) begin @(posedge clk); #2; end
         chk("hold_pass", g, 96'(pass[g]), 96'(r.pass));
         chk("hold_err", g, 96'(errc[g]), 96'(r.err));
         chk("hold_first", g, 96'(first[g]), 96'(r.first));
      end
      armed[g] = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog got=still running want=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int g;
      rst = '1; start = '0;
      for (int i = 0; i < NI; i++) begin mode[i] = 0; edge0[i] = 0; armed[i] = 1'b0; end
      repeat (3) @(posedge clk);
      #2;
      rst = '0;
      for (int i = 0; i < NI; i++) check_reset(i);
      run(0, 0, 0, 0);
      run(0, 1, 0, 0);
      run(0, 2, 0, 0);
      run(0, 0, 20, 0);
      run(0, 0, 0, 0);
      run(0, 0, 0, 10);
      run(0, 3, 0, 0);
      run(1, 0, 0, 0);
      run(1, 3, 0, 0);
      run(1, 2, 0, 3);
      run(2, 0, 0, 0);
      run(2, 1, 0, 2);
      for (int i = 0; i < 6; i++) begin
         g = int'($urandom_range(0, NI - 1));
         run(g, int'($urandom_range(0, 3)), 0,
             ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, NV[g])) : 0);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
